// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, the default
// mem_ready timeout and the byte-lane select encoding used by load_byte_align.
package lsu_pkg;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 15;
    localparam int unsigned LSU_WAIT_CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } lsu_state_e;

    // Lane n is bits [8n+7:8n] of the little-endian memory word.
    typedef enum logic [1:0] {
        LANE_B0 = 2'b00,
        LANE_B1 = 2'b01,
        LANE_B2 = 2'b10,
        LANE_B3 = 2'b11
    } byte_lane_e;

    function automatic logic [31:0] sign_extend_byte(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/load_byte_align.sv
// Combinational byte-lane extraction and sign extension for load-byte results.
module load_byte_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  byte_lane_e  i_lane,
    output logic [31:0] o_data
);

    logic [7:0] w_byte;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_lane)
            LANE_B0: w_byte = i_word[7:0];
            LANE_B1: w_byte = i_word[15:8];
            LANE_B2: w_byte = i_word[23:16];
            LANE_B3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
    end

    assign o_data = sign_extend_byte(w_byte);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load-byte / store-word unit with a req/ready memory port.
// Optional mem_ready timeout is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lb,
    input  logic        sw,
    input  logic [31:0] addr,
    input  logic [4:0]  rd,
    input  logic [31:0] data_out_dm,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] write_data_dm,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        busy,
    output logic        err
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("load_store_unit: TIMEOUT must be within 1..255");
    end

    lsu_state_e  r_state;
    logic        r_is_load;
    logic        r_misaligned;
    byte_lane_e  r_lane;
    logic [4:0]  r_rd;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_write_data;
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic        r_err;
    logic [31:0] w_load_data;

`ifdef LSU_TIMEOUT_EN
    localparam logic [LSU_WAIT_CNT_W-1:0] TIMEOUT_LAST = LSU_WAIT_CNT_W'(TIMEOUT - 1);
    logic [LSU_WAIT_CNT_W-1:0] r_wait_cnt;
`endif

    load_byte_align u_align (
        .i_word (mem_rdata),
        .i_lane (r_lane),
        .o_data (w_load_data)
    );

    // A misaligned store still spends one cycle in REQ (with mem_req low) before ERR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_is_load    <= 1'b0;
            r_misaligned <= 1'b0;
            r_lane       <= LANE_B0;
            r_rd         <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_write_data <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_err        <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_wait_cnt   <= '0;
`endif
        end else begin
            r_wb_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (lb || sw) begin
                        r_is_load    <= lb;
                        r_misaligned <= !lb && (addr[1:0] != 2'b00);
                        r_lane       <= byte_lane_e'(addr[1:0]);
                        r_rd         <= rd;
                        r_mem_addr   <= {addr[31:2], 2'b00};
                        r_mem_wdata  <= data_out_dm;
                        r_mem_req    <= lb || (addr[1:0] == 2'b00);
                        r_mem_we     <= !lb && (addr[1:0] == 2'b00);
                        r_state      <= REQ;
`ifdef LSU_TIMEOUT_EN
                        r_wait_cnt   <= '0;
`endif
                    end
                end
                REQ: begin
                    if (r_misaligned) begin
                        r_err   <= 1'b1;
                        r_state <= ERR;
                    end else if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_is_load) begin
                            r_write_data <= w_load_data;
                            r_wb_valid   <= 1'b1;
                            r_wb_rd      <= r_rd;
                        end
                        r_state <= DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (r_wait_cnt == TIMEOUT_LAST) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                DONE:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req       = r_mem_req;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign write_data_dm = r_write_data;
    assign wb_valid      = r_wb_valid;
    assign wb_rd         = r_wb_rd;
    assign err           = r_err;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a memory responder with configurable
// ready delay, and a writeback scoreboard fed by the scenario tasks.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        lb = 1'b0;
    logic        sw = 1'b0;
    logic [31:0] addr = '0;
    logic [4:0]  rd = '0;
    logic [31:0] data_out_dm = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req, mem_we, wb_valid, busy, err;
    logic [31:0] mem_addr, mem_wdata, write_data_dm;
    logic [4:0]  wb_rd;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t expQ[$];
    int checks = 0;
    int errors = 0;
    int wbSeen = 0;
    int readyDelay = 1;
    int reqSeen = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk           (clk),
        .reset         (reset),
        .lb            (lb),
        .sw            (sw),
        .addr          (addr),
        .rd            (rd),
        .data_out_dm   (data_out_dm),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .write_data_dm (write_data_dm),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .busy          (busy),
        .err           (err)
    );

    // Memory responder: ready on the readyDelay-th cycle of mem_req (0 = never).
    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            reqSeen   = reqSeen + 1;
            mem_ready = (readyDelay != 0) && (reqSeen >= readyDelay);
        end else begin
            reqSeen   = 0;
            mem_ready = 1'b0;
        end
    end

    // Scoreboard: every writeback pulse must match the oldest expected load.
    always @(negedge clk) begin : monitor_wb
        wb_exp_t e;
        if (reset === 1'b1 && wb_valid === 1'b1) begin
            wbSeen = wbSeen + 1;
            checks = checks + 1;
            if (expQ.size() == 0) begin
                errors = errors + 1;
                $display("[TB] FAIL unexpected_wb: got rd=%0d data=%h, expected no writeback", wb_rd, write_data_dm);
            end else begin
                e = expQ.pop_front();
                if (wb_rd !== e.rd || write_data_dm !== e.data) begin
                    errors = errors + 1;
                    $display("[TB] FAIL wb_result: got rd=%0d data=%h, expected rd=%0d data=%h",
                             wb_rd, write_data_dm, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] expected_byte(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] b;
        b = 8'(w >> (8 * lane));
        return {{24{b[7]}}, b};
    endfunction

    task automatic issue(input logic l, input logic s, input logic [31:0] a,
                         input logic [4:0] r, input logic [31:0] d);
        @(posedge clk); #1;
        lb = l; sw = s; addr = a; rd = r; data_out_dm = d;
        @(posedge clk); #1;
        lb = 1'b0; sw = 1'b0;
    endtask

    task automatic wait_idle(output bit timedOut);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        timedOut = (busy !== 1'b0);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({mem_req, mem_we, wb_valid, busy, err} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 00000", {mem_req, mem_we, wb_valid, busy, err});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || write_data_dm !== 32'h0 || wb_rd !== 5'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got addr=%h wdata=%h wd=%h rd=%0d, expected all zero",
                     mem_addr, mem_wdata, write_data_dm, wb_rd);
        end
        lb = 1'b1; addr = 32'h20;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold: got busy=%b mem_req=%b, expected 0 0", busy, mem_req);
        end
        lb = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_load_sign();
        mem_rdata = 32'h80FF_1234;
        readyDelay = 1;
        expQ.push_back('{rd: 5'd5, data: 32'hFFFF_FF80});
        issue(1'b1, 1'b0, 32'h103, 5'd5, 32'h0);
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, wb_valid} !== 3'b100 || mem_addr !== 32'h100) begin
            errors++;
            $display("[TB] FAIL load_req_cycle: got req=%b we=%b wbv=%b addr=%h, expected 1 0 0 00000100",
                     mem_req, mem_we, wb_valid, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || write_data_dm !== 32'hFFFF_FF80) begin
            errors++;
            $display("[TB] FAIL load_latency: got wbv=%b rd=%0d data=%h, expected 1 5 ffffff80",
                     wb_valid, wb_rd, write_data_dm);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_one_pulse: got wbv=%b busy=%b, expected 0 0", wb_valid, busy);
        end
    endtask

    task automatic test_store_wait();
        int  reqCycles;
        int  wbBefore;
        bit  done;
        reqCycles = 0;
        done = 1'b0;
        wbBefore = wbSeen;
        readyDelay = 4;
        issue(1'b0, 1'b1, 32'h200, 5'd0, 32'hDEAD_BEEF);
        lb = 1'b1; rd = 5'd9; addr = 32'h300;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            if (n == 1) lb = 1'b0;
            if (busy === 1'b0) begin
                done = 1'b1;
            end else if (mem_req === 1'b1) begin
                reqCycles++;
                checks++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h200, 32'hDEAD_BEEF}) begin
                    errors++;
                    $display("[TB] FAIL store_stable: got we=%b addr=%h wdata=%h, expected 1 00000200 deadbeef",
                             mem_we, mem_addr, mem_wdata);
                end
            end
        end
        checks++;
        if (!done || reqCycles != 4) begin
            errors++;
            $display("[TB] FAIL store_req_cycles: got %0d (done=%0d), expected 4", reqCycles, done);
        end
        checks++;
        if (write_data_dm !== 32'hFFFF_FF80 || wbSeen != wbBefore) begin
            errors++;
            $display("[TB] FAIL store_no_wb: got data=%h wb=%0d, expected ffffff80 0",
                     write_data_dm, wbSeen - wbBefore);
        end
    endtask

    task automatic test_misaligned();
        int busyCycles, reqHigh, errPulses;
        bit done;
        busyCycles = 0; reqHigh = 0; errPulses = 0; done = 1'b0;
        readyDelay = 1;
        issue(1'b0, 1'b1, 32'h202, 5'd0, 32'h1234_5678);
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (busy === 1'b1) busyCycles++;
            else done = 1'b1;
            if (mem_req === 1'b1) reqHigh++;
            if (err === 1'b1) errPulses++;
        end
        checks++;
        if (!done || busyCycles != 2 || reqHigh != 0 || errPulses != 1) begin
            errors++;
            $display("[TB] FAIL misaligned_store: got busy=%0d req=%0d err=%0d, expected 2 0 1",
                     busyCycles, reqHigh, errPulses);
        end
    endtask

    task automatic test_priority();
        bit to;
        mem_rdata = 32'h0000_007F;
        readyDelay = 1;
        expQ.push_back('{rd: 5'd7, data: 32'h0000_007F});
        issue(1'b1, 1'b1, 32'h10, 5'd7, 32'hCAFE_F00D);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin
            errors++;
            $display("[TB] FAIL lb_priority: got req=%b we=%b addr=%h, expected 1 0 00000010",
                     mem_req, mem_we, mem_addr);
        end
        wait_idle(to);
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL priority_idle: got busy after bound, expected idle");
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int wbBefore;
        logic [4:0] rdv;
        wbBefore = wbSeen;
        mem_rdata = 32'h8142_C324;
        for (int lane = 0; lane < 4; lane++) begin
            readyDelay = 1 + (lane % 2);
            rdv = (lane == 0) ? 5'd0 : 5'(lane + 10);
            expQ.push_back('{rd: rdv, data: expected_byte(mem_rdata, 2'(lane))});
            issue(1'b1, 1'b0, 32'h400 | 32'(lane), rdv, 32'h0);
            wait_idle(to);
            checks++;
            if (to) begin
                errors++;
                $display("[TB] FAIL lane_idle: lane %0d still busy after bound, expected idle", lane);
            end
        end
        checks++;
        if (wbSeen - wbBefore != 4) begin
            errors++;
            $display("[TB] FAIL lane_wb_count: got %0d, expected 4", wbSeen - wbBefore);
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int reqHigh, errPulses, wbBefore;
        bit done;
        reqHigh = 0; errPulses = 0; done = 1'b0;
        wbBefore = wbSeen;
        readyDelay = 0;
        issue(1'b1, 1'b0, 32'h500, 5'd3, 32'h0);
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) done = 1'b1;
            if (mem_req === 1'b1) reqHigh++;
            if (err === 1'b1) errPulses++;
        end
        checks++;
        if (!done || reqHigh != 15 || errPulses != 1 || wbSeen != wbBefore) begin
            errors++;
            $display("[TB] FAIL timeout: got req=%0d err=%0d wb=%0d done=%0d, expected 15 1 0 1",
                     reqHigh, errPulses, wbSeen - wbBefore, done);
        end
    endtask
`endif

    task automatic test_reset_mid_access();
        int wbBefore;
        readyDelay = 0;
        mem_rdata = 32'h1111_2222;
        issue(1'b1, 1'b0, 32'h40, 5'd4, 32'h0);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_setup: got mem_req=%b, expected 1", mem_req);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, busy, wb_valid, err} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL abort_ctrl: got %b, expected 0000", {mem_req, busy, wb_valid, err});
        end
        checks++;
        if (mem_addr !== 32'h0 || write_data_dm !== 32'h0 || wb_rd !== 5'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL abort_data: got addr=%h wd=%h rd=%0d wdata=%h, expected all zero",
                     mem_addr, write_data_dm, wb_rd, mem_wdata);
        end
        readyDelay = 1;
        @(negedge clk);
        reset = 1'b1;
        wbBefore = wbSeen;
        repeat (6) @(negedge clk);
        checks++;
        if (wbSeen != wbBefore || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_wb: got wb=%0d busy=%b, expected 0 0", wbSeen - wbBefore, busy);
        end
    endtask

    initial begin
        $display("[TB] starting load_store_unit bench");
        test_reset();
        test_load_sign();
        test_store_wait();
        test_misaligned();
        test_priority();
        test_back_to_back();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_access();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL be the maximum number of cycles spent waiting for mem_ready (range 1..255).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 lb  input  1  SHALL request a load-byte into register rd.
REQ-005 sw  input  1  SHALL request a store-word of data_out_dm.
REQ-006 addr  input  32  SHALL be the effective byte address of the access.
REQ-007 rd  input  5  SHALL be the destination register index for loads.
REQ-008 data_out_dm  input  32  SHALL be the store data from the register file.
REQ-009 mem_req, mem_we  output  1 each  SHALL be the memory request strobe and the write enable.
REQ-010 mem_addr, mem_wdata  output  32 each  SHALL be the word-aligned memory address ({addr[31:2],2'b00}) and the write data.
REQ-011 mem_ready  input  1, mem_rdata  input  32  SHALL be the memory completion strobe and the read word.
REQ-012 write_data_dm  output  32, wb_valid  output  1, wb_rd  output  5  SHALL be the load result, its write strobe and its destination index toward the register file.
REQ-013 busy  output  1, err  output  1  SHALL be the unit-occupied flag and the one-cycle error pulse.

Function
REQ-014 FSM states SHALL be IDLE, REQ, DONE and ERR.
REQ-015 In IDLE with lb or sw high, the unit SHALL register addr, rd, data_out_dm and the operation type, then move to REQ on the next edge.
REQ-016 If lb and sw are both high, lb SHALL win and sw SHALL be dropped.
REQ-017 A request with addr[1:0]!=2'b00 on sw SHALL go to ERR without asserting mem_req.
REQ-018 In REQ, mem_req SHALL be held high with stable mem_addr, mem_we and mem_wdata until the cycle mem_ready is sampled high.
REQ-019 On mem_ready in REQ, a load SHALL select byte lane addr[1:0] of mem_rdata, sign-extend it to 32 bits into write_data_dm, and move to DONE.
REQ-020 On mem_ready in REQ, a store SHALL move to DONE with write_data_dm unchanged.
REQ-021 In DONE, wb_valid SHALL be high for exactly one cycle for loads only, with wb_rd equal to the captured rd; the FSM then returns to IDLE.
REQ-022 ERR SHALL pulse err for one cycle, keep wb_valid low and return to IDLE.
REQ-023 busy SHALL be high in every state except IDLE; lb and sw SHALL be ignored while busy.
REQ-024 Minimum latency from request to wb_valid SHALL be 3 cycles when mem_ready is high on the first REQ cycle.
REQ-025 A load to rd=0 SHALL still complete, with wb_valid asserted; the register file is responsible for discarding the write.

Reset
REQ-026 While reset is low, the FSM SHALL be in IDLE and mem_req, mem_we, wb_valid, busy and err SHALL be 0.
REQ-027 While reset is low, mem_addr, mem_wdata, write_data_dm and wb_rd SHALL be 0, with the wait counter cleared.
REQ-028 A reset asserted mid-access SHALL abort the access immediately, with no wb_valid pulse after release.

Configuration
REQ-029 With LSU_TIMEOUT_EN defined, an 8-bit counter SHALL count REQ cycles; if TIMEOUT cycles pass without mem_ready, mem_req SHALL drop and the FSM SHALL go to ERR.
REQ-030 Without LSU_TIMEOUT_EN, no counter SHALL exist, REQ SHALL wait indefinitely, and err SHALL signal only misaligned stores.

Structure
REQ-031 Package lsu_pkg SHALL hold the state enum, TIMEOUT default and the byte-lane select encoding.
REQ-032 Byte selection and sign extension SHALL be a combinational sub-module named load_byte_align.

Verification
REQ-033 Scenario: lb, addr=0x103, mem_rdata=0x80FF_1234 and mem_ready high on the first REQ cycle -> write_data_dm=0xFFFF_FF80 with wb_valid 3 cycles after the request.
REQ-034 Scenario: sw, addr=0x200, data_out_dm=0xDEAD_BEEF, mem_ready after 4 cycles -> mem_req high for 4 cycles with mem_we=1, mem_wdata=0xDEAD_BEEF, and no wb_valid.
REQ-035 Scenario: sw, addr=0x202 -> err pulse, mem_req never high, busy high for 2 cycles.
REQ-036 Scenario: lb and sw both high, addr=0x10 -> load performed with mem_we=0.
REQ-037 Scenario: LSU_TIMEOUT_EN defined, TIMEOUT=15, mem_ready held low -> mem_req drops after 15 cycles, err pulses, and the FSM returns to IDLE.
REQ-038 Scenario: reset driven low during REQ -> mem_req=0 immediately and no wb_valid after release.
